// File: rtl/ctrl_bcm_matrix_pkg.sv
// ctrl_bcm_matrix_pkg
//   Shared definitions for the HUB75 BCM scan controller.
//   - State encoding constants for the scan FSM.
//   - width_of(): address width helper, never narrower than one bit.
package ctrl_bcm_matrix_pkg;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StShift   = 3'd1;
    localparam logic [2:0] StGuard   = 3'd2;
    localparam logic [2:0] StLatch   = 3'd3;
    localparam logic [2:0] StDisplay = 3'd4;
    localparam logic [2:0] StNext    = 3'd5;

    function automatic int unsigned width_of(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ctrl_bcm_matrix_if.sv
// ctrl_bcm_matrix_if
//   Control and panel-side signals of the BCM scan controller.
//   init, dim        : frame start request and brightness shift (into the controller)
//   col, row, bit_idx: frame-buffer read address / panel row address
//   px_clk_en, latch, noe: panel strobes (noe active low)
//   busy, frame_done : status
//   master modport = controller, slave modport = the system driving it.
interface ctrl_bcm_matrix_if
    import ctrl_bcm_matrix_pkg::*;
#(
    parameter int unsigned COLS = 64,
    parameter int unsigned ROWS = 32,
    parameter int unsigned BITS = 4
) ();
    localparam int unsigned COL_W = width_of(COLS);
    localparam int unsigned ROW_W = width_of(ROWS);
    localparam int unsigned BIT_W = width_of(BITS);

    logic             init;
    logic [1:0]       dim;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [BIT_W-1:0] bit_idx;
    logic             px_clk_en;
    logic             latch;
    logic             noe;
    logic             busy;
    logic             frame_done;

    modport master (
        input  init, dim,
        output col, row, bit_idx, px_clk_en, latch, noe, busy, frame_done
    );

    modport slave (
        output init, dim,
        input  col, row, bit_idx, px_clk_en, latch, noe, busy, frame_done
    );
endinterface

// File: rtl/ctrl_bcm_matrix_delay_counter.sv
// ctrl_bcm_matrix_delay_counter
//   Per-plane display timer for binary-coded modulation.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_load       : capture i_weight / i_on_len and clear the count (LATCH cycle)
//   i_run        : count one display cycle
//   i_weight     : full display length of the plane in cycles
//   i_on_len     : cycles of the plane during which the LEDs are lit
//   o_done       : last display cycle of the plane
//   o_on_window  : current display cycle lies inside the lit window
module ctrl_bcm_matrix_delay_counter #(
    parameter int unsigned DLY_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_run,
    input  logic [DLY_W-1:0] i_weight,
    input  logic [DLY_W-1:0] i_on_len,
    output logic             o_done,
    output logic             o_on_window
);
    logic [DLY_W-1:0] r_dly;
    logic [DLY_W-1:0] r_weight;
    logic [DLY_W-1:0] r_on_len;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dly    <= '0;
            r_weight <= '0;
            r_on_len <= '0;
        end else if (i_load) begin
            r_dly    <= '0;
            r_weight <= i_weight;
            r_on_len <= i_on_len;
        end else if (i_run) begin
            r_dly <= r_dly + DLY_W'(1);
        end
    end

    assign o_done      = (r_dly == r_weight - DLY_W'(1));
    assign o_on_window = (r_dly < r_on_len);
endmodule

// File: rtl/ctrl_bcm_matrix.sv
// ctrl_bcm_matrix
//   HUB75 LED-matrix scan controller with binary-coded modulation.
//   Per row and bit-plane: shift COLS pixels, blank for BLANK cycles, latch,
//   display for BASE_DELAY<<bit_idx cycles (lit for that >> dim), then advance.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (master) : init/dim in; col/row/bit_idx, px_clk_en/latch/noe, busy/frame_done out
module ctrl_bcm_matrix
    import ctrl_bcm_matrix_pkg::*;
#(
    parameter int unsigned COLS       = 64,
    parameter int unsigned ROWS       = 32,
    parameter int unsigned BITS       = 4,
    parameter int unsigned BASE_DELAY = 64,
    parameter int unsigned BLANK      = 2,
    parameter int unsigned CONTINUOUS = 0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    ctrl_bcm_matrix_if.master   bus
);
    localparam int unsigned COL_W = width_of(COLS);
    localparam int unsigned ROW_W = width_of(ROWS);
    localparam int unsigned BIT_W = width_of(BITS);
    localparam int unsigned GRD_W = width_of(BLANK);
    localparam int unsigned DLY_W = $clog2(BASE_DELAY) + BITS;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS - 1);
    localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(BLANK - 1);

    logic [2:0]       r_state, w_state_d;
    logic [COL_W-1:0] r_col,   w_col_d;
    logic [ROW_W-1:0] r_row,   w_row_d;
    logic [BIT_W-1:0] r_bit,   w_bit_d;
    logic [GRD_W-1:0] r_guard, w_guard_d;

    logic [DLY_W-1:0] w_weight;
    logic [DLY_W-1:0] w_on_len;
    logic             w_dly_done;
    logic             w_on_window;
    logic             w_last_plane;

    // Full plane weight sets the frame rate; dim only shortens the lit part.
    assign w_weight     = DLY_W'(BASE_DELAY) << r_bit;
    assign w_on_len     = w_weight >> bus.dim;
    assign w_last_plane = (r_bit == BIT_LAST) && (r_row == ROW_LAST);

    ctrl_bcm_matrix_delay_counter #(
        .DLY_W (DLY_W)
    ) u_delay (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (r_state == StLatch),
        .i_run       (r_state == StDisplay),
        .i_weight    (w_weight),
        .i_on_len    (w_on_len),
        .o_done      (w_dly_done),
        .o_on_window (w_on_window)
    );

    always_comb begin
        w_state_d = r_state;
        w_col_d   = r_col;
        w_row_d   = r_row;
        w_bit_d   = r_bit;
        w_guard_d = r_guard;
        case (r_state)
            StIdle: begin
                if (bus.init) begin
                    w_state_d = StShift;
                    w_col_d   = '0;
                end
            end
            StShift: begin
                if (r_col == COL_LAST) begin
                    w_col_d   = '0;
                    w_guard_d = '0;
                    w_state_d = StGuard;
                end else begin
                    w_col_d = r_col + COL_W'(1);
                end
            end
            StGuard: begin
                if (r_guard == GRD_LAST) begin
                    w_state_d = StLatch;
                end else begin
                    w_guard_d = r_guard + GRD_W'(1);
                end
            end
            StLatch: begin
                w_state_d = StDisplay;
            end
            StDisplay: begin
                if (w_dly_done) begin
                    w_state_d = StNext;
                end
            end
            StNext: begin
                // row/bit_idx only move here, while NOE is high.
                if (r_bit != BIT_LAST) begin
                    w_bit_d   = r_bit + BIT_W'(1);
                    w_state_d = StShift;
                end else begin
                    w_bit_d = '0;
                    if (r_row == ROW_LAST) begin
                        w_row_d   = '0;
                        w_state_d = ((CONTINUOUS != 0) || bus.init) ? StShift : StIdle;
                    end else begin
                        w_row_d   = r_row + ROW_W'(1);
                        w_state_d = StShift;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_col   <= '0;
            r_row   <= '0;
            r_bit   <= '0;
            r_guard <= '0;
        end else begin
            r_state <= w_state_d;
            r_col   <= w_col_d;
            r_row   <= w_row_d;
            r_bit   <= w_bit_d;
            r_guard <= w_guard_d;
        end
    end

    assign bus.col        = r_col;
    assign bus.row        = r_row;
    assign bus.bit_idx    = r_bit;
    assign bus.px_clk_en  = (r_state == StShift);
    assign bus.latch      = (r_state == StLatch);
    assign bus.noe        = !((r_state == StDisplay) && w_on_window);
    assign bus.busy       = (r_state != StIdle);
    assign bus.frame_done = (r_state == StNext) && w_last_plane;
endmodule

// File: tb/tb_ctrl_bcm_matrix.sv
// tb_ctrl_bcm_matrix
//   Self-checking bench for ctrl_bcm_matrix (COLS=4, ROWS=2, BITS=2, BASE_DELAY=4, BLANK=2).
//   A second instance with CONTINUOUS=1 shares clock, reset and inputs.
//   The expected per-cycle output trace of a frame is built from the plane timing rules.
module tb_ctrl_bcm_matrix;
    import ctrl_bcm_matrix_pkg::*;

    localparam int unsigned COLS       = 4;
    localparam int unsigned ROWS       = 2;
    localparam int unsigned BITS       = 2;
    localparam int unsigned BASE_DELAY = 4;
    localparam int unsigned BLANK      = 2;
    localparam int unsigned COL_W      = width_of(COLS);
    localparam int unsigned ROW_W      = width_of(ROWS);
    localparam int unsigned BIT_W      = width_of(BITS);
    localparam int unsigned OW         = COL_W + ROW_W + BIT_W + 5;

    typedef logic [OW-1:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    int   dim_seq [512];
    vec_t exp_q [$];
    vec_t obs_q [$];
    vec_t obs_c_q [$];

    ctrl_bcm_matrix_if #(.COLS(COLS), .ROWS(ROWS), .BITS(BITS)) u_if ();
    ctrl_bcm_matrix_if #(.COLS(COLS), .ROWS(ROWS), .BITS(BITS)) u_if_c ();

    assign u_if_c.init = u_if.init;
    assign u_if_c.dim  = u_if.dim;

    ctrl_bcm_matrix #(
        .COLS(COLS), .ROWS(ROWS), .BITS(BITS), .BASE_DELAY(BASE_DELAY),
        .BLANK(BLANK), .CONTINUOUS(0)
    ) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (u_if)
    );

    ctrl_bcm_matrix #(
        .COLS(COLS), .ROWS(ROWS), .BITS(BITS), .BASE_DELAY(BASE_DELAY),
        .BLANK(BLANK), .CONTINUOUS(1)
    ) u_dut_c (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (u_if_c)
    );

    always #5 clk = ~clk;

    function automatic vec_t pack(int c, int r, int b, bit px, bit la, bit noe, bit busy,
                                  bit fd);
        logic [COL_W-1:0] cv;
        logic [ROW_W-1:0] rv;
        logic [BIT_W-1:0] bv;
        cv = COL_W'(c);
        rv = ROW_W'(r);
        bv = BIT_W'(b);
        return {cv, rv, bv, px, la, noe, busy, fd};
    endfunction

    function automatic vec_t obs_main();
        return {u_if.col, u_if.row, u_if.bit_idx, u_if.px_clk_en, u_if.latch, u_if.noe,
                u_if.busy, u_if.frame_done};
    endfunction

    function automatic vec_t obs_cont();
        return {u_if_c.col, u_if_c.row, u_if_c.bit_idx, u_if_c.px_clk_en, u_if_c.latch,
                u_if_c.noe, u_if_c.busy, u_if_c.frame_done};
    endfunction

    function automatic vec_t idle_vec();
        return pack(0, 0, 0, 0, 0, 1, 0, 0);
    endfunction

    // Reference model: one frame, cycle 0 = first SHIFT; dim_seq[t] is the dim present in cycle t.
    task automatic build_trace();
        int weight;
        int on_len;
        exp_q.delete();
        for (int r = 0; r < ROWS; r++) begin
            for (int b = 0; b < BITS; b++) begin
                weight = BASE_DELAY * (2 ** b);
                for (int c = 0; c < COLS; c++) exp_q.push_back(pack(c, r, b, 1, 0, 1, 1, 0));
                for (int g = 0; g < BLANK; g++) exp_q.push_back(pack(0, r, b, 0, 0, 1, 1, 0));
                on_len = weight / (2 ** dim_seq[exp_q.size()]);
                exp_q.push_back(pack(0, r, b, 0, 1, 1, 1, 0));
                for (int k = 0; k < weight; k++)
                    exp_q.push_back(pack(0, r, b, 0, 0, (k >= on_len), 1, 0));
                exp_q.push_back(pack(0, r, b, 0, 0, 1, 1,
                                     (r == ROWS - 1) && (b == BITS - 1)));
            end
        end
    endtask

    task automatic fill_dims(input int mode);
        for (int i = 0; i < 512; i++) dim_seq[i] = (mode < 0) ? int'($urandom_range(0, 3)) : mode;
    endtask

    task automatic start_frame();
        u_if.init = 1'b1;
        @(posedge clk);
        #1;
        u_if.init = 1'b0;
    endtask

    // Drives n cycles of a frame and records both instances' outputs.
    task automatic capture(input int n, input bit rand_init, input bit end_init);
        obs_q.delete();
        obs_c_q.delete();
        for (int t = 0; t < n; t++) begin
            u_if.dim  = 2'(dim_seq[t]);
            u_if.init = (t == n - 1) ? end_init : (rand_init ? 1'($urandom_range(0, 1)) : 1'b0);
            obs_q.push_back(obs_main());
            obs_c_q.push_back(obs_cont());
            @(posedge clk);
            #1;
        end
        u_if.init = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (obs_main() !== idle_vec())
            $display("FAIL reset_state: got %b expected %b", obs_main(), idle_vec());
        else n_pass++;
        rst = 1'b0;
        fill_dims(0);
        start_frame();
        capture(5, 1, 0);
        rst       = 1'b1;
        u_if.init = 1'b1;
        u_if.dim  = 2'($urandom_range(0, 3));
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (obs_main() !== idle_vec())
                $display("FAIL reset_priority[%0d]: got %b expected %b", i, obs_main(), idle_vec());
            else n_pass++;
        end
        rst       = 1'b0;
        u_if.init = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (obs_main() !== idle_vec())
            $display("FAIL idle_hold: got %b expected %b", obs_main(), idle_vec());
        else n_pass++;
    endtask

    task automatic test_frame(input int dim);
        fill_dims(dim);
        build_trace();
        start_frame();
        capture(exp_q.size(), 0, 0);
        for (int t = 0; t < exp_q.size(); t++) begin
            n_checks++;
            if (obs_q[t] !== exp_q[t])
                $display("FAIL frame_dim%0d cycle %0d: got %b expected %b", dim, t, obs_q[t],
                         exp_q[t]);
            else n_pass++;
        end
        n_checks++;
        if (obs_main() !== idle_vec())
            $display("FAIL frame_dim%0d_end_idle: got %b expected %b", dim, obs_main(), idle_vec());
        else n_pass++;
    endtask

    task automatic test_random_dim();
        for (int f = 0; f < 3; f++) begin
            fill_dims(-1);
            build_trace();
            start_frame();
            capture(exp_q.size(), 1, 0);
            for (int t = 0; t < exp_q.size(); t++) begin
                n_checks++;
                if (obs_q[t] !== exp_q[t])
                    $display("FAIL random_f%0d cycle %0d: got %b expected %b", f, t, obs_q[t],
                             exp_q[t]);
                else n_pass++;
            end
            n_checks++;
            if (obs_main() !== idle_vec())
                $display("FAIL random_f%0d_idle: got %b expected %b", f, obs_main(), idle_vec());
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        fill_dims(-1);
        build_trace();
        start_frame();
        for (int f = 0; f < 2; f++) begin
            capture(exp_q.size(), 0, (f == 0));
            for (int t = 0; t < exp_q.size(); t++) begin
                n_checks++;
                if (obs_q[t] !== exp_q[t])
                    $display("FAIL b2b_f%0d cycle %0d: got %b expected %b", f, t, obs_q[t],
                             exp_q[t]);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_main() !== idle_vec())
            $display("FAIL b2b_idle: got %b expected %b", obs_main(), idle_vec());
        else n_pass++;
    endtask

    task automatic test_continuous();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        fill_dims(-1);
        build_trace();
        start_frame();
        capture(exp_q.size(), 0, 0);
        for (int t = 0; t < exp_q.size(); t++) begin
            n_checks++;
            if (obs_c_q[t] !== exp_q[t])
                $display("FAIL cont cycle %0d: got %b expected %b", t, obs_c_q[t], exp_q[t]);
            else n_pass++;
        end
        n_checks++;
        if (obs_main() !== idle_vec())
            $display("FAIL cont_ref_idle: got %b expected %b", obs_main(), idle_vec());
        else n_pass++;
        for (int t = 0; t < 4; t++) begin
            n_checks++;
            if (obs_cont() !== exp_q[t])
                $display("FAIL cont_restart cycle %0d: got %b expected %b", t, obs_cont(),
                         exp_q[t]);
            else n_pass++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_mid_reset();
        int t_rst;
        fill_dims(-1);
        build_trace();
        t_rst = exp_q.size() / ROWS + COLS + BLANK + 1 + int'($urandom_range(0, BASE_DELAY - 1));
        start_frame();
        capture(t_rst, 0, 0);
        for (int t = 0; t < t_rst; t++) begin
            n_checks++;
            if (obs_q[t] !== exp_q[t])
                $display("FAIL midrst_pre cycle %0d: got %b expected %b", t, obs_q[t], exp_q[t]);
            else n_pass++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (obs_main() !== idle_vec())
            $display("FAIL midrst_abort: got %b expected %b", obs_main(), idle_vec());
        else n_pass++;
        rst = 1'b0;
        start_frame();
        capture(exp_q.size(), 0, 0);
        for (int t = 0; t < exp_q.size(); t++) begin
            n_checks++;
            if (obs_q[t] !== exp_q[t])
                $display("FAIL midrst_restart cycle %0d: got %b expected %b", t, obs_q[t],
                         exp_q[t]);
            else n_pass++;
        end
    endtask

    // Cycle-by-cycle invariants on the non-continuous instance.
    logic [ROW_W-1:0] prev_row = '0;
    logic [BIT_W-1:0] prev_bit = '0;
    logic             prev_noe = 1'b1;
    logic             prev_rst = 1'b1;

    always @(negedge clk) begin
        if (!prev_rst && !rst) begin
            n_checks++;
            if (u_if.latch && u_if.px_clk_en)
                $display("FAIL inv_strobe: got latch=%b px=%b required not both 1", u_if.latch,
                         u_if.px_clk_en);
            else n_pass++;
            n_checks++;
            if ((int'(u_if.col) >= COLS) || (!u_if.px_clk_en && (u_if.col != '0)))
                $display("FAIL inv_col: got col=%0d px=%b required col<%0d and 0 outside shift",
                         u_if.col, u_if.px_clk_en, COLS);
            else n_pass++;
            if ((u_if.row != prev_row) || (u_if.bit_idx != prev_bit)) begin
                n_checks++;
                if (!(u_if.noe && prev_noe))
                    $display("FAIL inv_noe_on_change: got noe=%b prev=%b required 1/1",
                             u_if.noe, prev_noe);
                else n_pass++;
            end
        end
        prev_row = u_if.row;
        prev_bit = u_if.bit_idx;
        prev_noe = u_if.noe;
        prev_rst = rst;
    end

    initial begin
        u_if.init = 1'b0;
        u_if.dim  = 2'd0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_frame(0);
        test_frame(1);
        test_frame(3);
        test_random_dim();
        test_back_to_back();
        test_mid_reset();
        test_continuous();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
